pipelined_control_unit: RTL and testbench

- Next-generation ID-stage control unit for the ARM pipeline. Decodes the 32-bit instruction register and evaluates the condition field against NZCV.
- Registers all control signals into the ID/EX control latch.
- Contains a micro-sequencer that expands load/store-multiple (class 100) into one single-register transfer per cycle, holding fetch until done.
- Sits between the IF/ID register and the EX stage; takes hazard stall and branch flush inputs.

---
 rtl/ctrl_pkg.sv | 83 ++++++++
 rtl/block_xfer_seq.sv | 109 ++++++++++
 rtl/pipelined_control_unit.sv | 160 ++++++++++++++++
 tb/tb_pipelined_control_unit.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the ID-stage control unit: instruction classes, ALU
// opcodes, condition codes, transfer sizes and the ID/EX control latch layout.
package ctrl_pkg;

  localparam logic [2:0] CLS_DP_REG  = 3'b000;
  localparam logic [2:0] CLS_DP_IMM  = 3'b001;
  localparam logic [2:0] CLS_LS_IMM  = 3'b010;
  localparam logic [2:0] CLS_LS_REG  = 3'b011;
  localparam logic [2:0] CLS_BLOCK   = 3'b100;
  localparam logic [2:0] CLS_BRANCH  = 3'b101;
  localparam logic [2:0] CLS_UNDEF_A = 3'b110;
  localparam logic [2:0] CLS_UNDEF_B = 3'b111;

  localparam logic [3:0] ALU_ADD = 4'b0100;
  localparam logic [3:0] ALU_SUB = 4'b0010;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic {
    SEQ_IDLE = 1'b0,
    SEQ_XFER = 1'b1
  } seq_state_e;

  typedef struct packed {
    logic       valid;
    logic [3:0] opcode;
    logic       se;
    logic       li;
    logic       rf;
    logic       rw;
    logic       b;
    logic       bl;
    logic       s;
    logic [1:0] size;
    logic       undef;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    logic pass;
    {n, z, c, v} = nzcv;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
    return pass;
  endfunction

endpackage

// File: rtl/block_xfer_seq.sv
// Micro-sequencer that expands a load/store-multiple register list into one
// single-register beat per cycle, lowest register first.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// SEQ_IDLE | no transfer pending; beat 0 is emitted straight from list_in
// SEQ_XFER | beats remain in list_q; fetch is held and ir_in is ignored
module block_xfer_seq
  import ctrl_pkg::*;
#(
  parameter int NUM_REGS  = 16,
  parameter int REG_IDX_W = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [NUM_REGS-1:0]  list_in,
  input  logic                 rw_in,
  input  logic                 u_in,
  input  logic                 stall,
  input  logic                 flush,
  output logic                 beat_valid,
  output logic [REG_IDX_W-1:0] beat_idx,
  output logic [REG_IDX_W+1:0] beat_offset,
  output logic                 beat_rw,
  output logic                 beat_u,
  output logic                 busy
);

  seq_state_e            state_q, state_d;
  logic [NUM_REGS-1:0]   list_q, list_d;
  logic [REG_IDX_W-1:0]  cnt_q, cnt_d;
  logic                  rw_q, rw_d;
  logic                  u_q, u_d;
  logic [NUM_REGS-1:0]   src_list;
  logic [NUM_REGS-1:0]   beat_mask;

  assign busy     = (state_q == SEQ_XFER);
  assign src_list = busy ? list_q : list_in;

  // Scan from the top so the last hit, i.e. the lowest set bit, wins.
  always_comb begin
    beat_idx = '0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (src_list[i]) beat_idx = REG_IDX_W'(i);
    end
  end

  always_comb begin
    beat_mask           = '0;
    beat_mask[beat_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SEQ_IDLE;
      list_q  <= '0;
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      u_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      list_q  <= list_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      u_q     <= u_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    list_d      = list_q;
    cnt_d       = cnt_q;
    rw_d        = rw_q;
    u_d         = u_q;
    beat_valid  = 1'b0;
    beat_offset = '0;
    beat_rw     = rw_q;
    beat_u      = u_q;
    case (state_q)
      SEQ_IDLE: begin
        beat_rw = rw_in;
        beat_u  = u_in;
        if (start) begin
          beat_valid = 1'b1;
          list_d     = list_in & ~beat_mask;
          cnt_d      = REG_IDX_W'(1);
          rw_d       = rw_in;
          u_d        = u_in;
          if ((list_in & ~beat_mask) != '0) state_d = SEQ_XFER;
        end
      end
      SEQ_XFER: begin
        beat_offset = {cnt_q, 2'b00};
        if (flush) begin
          state_d = SEQ_IDLE;
          list_d  = '0;
        end else if (!stall) begin
          beat_valid = 1'b1;
          list_d     = list_q & ~beat_mask;
          cnt_d      = cnt_q + REG_IDX_W'(1);
          if ((list_q & ~beat_mask) == '0) state_d = SEQ_IDLE;
        end
      end
      default: state_d = SEQ_IDLE;
    endcase
  end

endmodule

// File: rtl/pipelined_control_unit.sv
// ID-stage control unit: decodes the instruction, evaluates its condition and
// registers the resulting controls into the ID/EX latch.
module pipelined_control_unit
  import ctrl_pkg::*;
#(
  parameter int NUM_REGS  = 16,
  parameter int REG_IDX_W = 4,
  parameter bit COND_EN   = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [31:0]          ir_in,
  input  logic                 ir_valid,
  input  logic [3:0]           flags_in,
  input  logic                 stall_in,
  input  logic                 flush_in,
  output logic                 hold_fetch_out,
  output logic                 valid_ex,
  output logic [3:0]           opcode_ex,
  output logic                 se_ex,
  output logic                 li_ex,
  output logic                 rf_ex,
  output logic                 rw_ex,
  output logic                 b_ex,
  output logic                 bl_ex,
  output logic                 s_ex,
  output logic [1:0]           size_ex,
  output logic [REG_IDX_W-1:0] xfer_reg_ex,
  output logic [REG_IDX_W+1:0] offset_ex,
  output logic                 undef_ex
);

  ctrl_t                 ctrl_q, ctrl_d;
  logic [REG_IDX_W-1:0]  xfer_q, xfer_d;
  logic [REG_IDX_W+1:0]  off_q, off_d;
  logic [2:0]            ir_cls;
  logic [NUM_REGS-1:0]   ir_list;
  logic                  cond_ok;
  logic                  list_nz;
  logic                  seq_start;
  logic                  beat_valid;
  logic [REG_IDX_W-1:0]  beat_idx;
  logic [REG_IDX_W+1:0]  beat_offset;
  logic                  beat_rw;
  logic                  beat_u;
  logic                  busy;
  logic                  unused_ir;

  // Base register field is consumed by EX from the raw instruction, not here.
  assign unused_ir = ^ir_in[19:16];

  assign ir_cls    = ir_in[27:25];
  assign ir_list   = ir_in[NUM_REGS-1:0];
  assign list_nz   = (ir_list != '0);
  assign cond_ok   = COND_EN ? cond_pass(ir_in[31:28], flags_in) : 1'b1;
  assign seq_start = !busy && ir_valid && cond_ok && (ir_cls == CLS_BLOCK) &&
                     list_nz && !stall_in && !flush_in;

  block_xfer_seq #(
    .NUM_REGS  (NUM_REGS),
    .REG_IDX_W (REG_IDX_W)
  ) u_seq (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (seq_start),
    .list_in     (ir_list),
    .rw_in       (ir_in[20]),
    .u_in        (ir_in[23]),
    .stall       (stall_in),
    .flush       (flush_in),
    .beat_valid  (beat_valid),
    .beat_idx    (beat_idx),
    .beat_offset (beat_offset),
    .beat_rw     (beat_rw),
    .beat_u      (beat_u),
    .busy        (busy)
  );

  assign hold_fetch_out = busy;

  always_comb begin
    ctrl_d = CTRL_BUBBLE;
    xfer_d = '0;
    off_d  = '0;
    if (beat_valid) begin
      ctrl_d.valid  = 1'b1;
      ctrl_d.li     = 1'b1;
      ctrl_d.rw     = beat_rw;
      ctrl_d.rf     = beat_rw;
      ctrl_d.size   = SIZE_WORD;
      ctrl_d.opcode = beat_u ? ALU_ADD : ALU_SUB;
      xfer_d        = beat_idx;
      off_d         = beat_offset;
    end else if (!busy && ir_valid && cond_ok) begin
      case (ir_cls)
        CLS_DP_REG, CLS_DP_IMM: begin
          ctrl_d.valid  = 1'b1;
          ctrl_d.opcode = ir_in[24:21];
          ctrl_d.se     = (ir_cls == CLS_DP_REG);
          ctrl_d.s      = ir_in[20];
          // Test/compare opcodes (10xx) only set flags.
          ctrl_d.rf     = (ir_in[24:23] != 2'b10);
        end
        CLS_LS_IMM, CLS_LS_REG: begin
          ctrl_d.valid  = 1'b1;
          ctrl_d.li     = 1'b1;
          ctrl_d.se     = (ir_cls == CLS_LS_REG);
          ctrl_d.rw     = ir_in[20];
          ctrl_d.rf     = ir_in[20];
          ctrl_d.size   = ir_in[22] ? SIZE_BYTE : SIZE_WORD;
          ctrl_d.opcode = ir_in[23] ? ALU_ADD : ALU_SUB;
        end
        CLS_BRANCH: begin
          ctrl_d.valid  = 1'b1;
          ctrl_d.b      = 1'b1;
          ctrl_d.bl     = ir_in[24];
          ctrl_d.rf     = ir_in[24];
          ctrl_d.opcode = ALU_ADD;
        end
        CLS_BLOCK:                ctrl_d.undef = !list_nz;
        CLS_UNDEF_A, CLS_UNDEF_B: ctrl_d.undef = 1'b1;
        default:                  ctrl_d = CTRL_BUBBLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q <= CTRL_BUBBLE;
      xfer_q <= '0;
      off_q  <= '0;
    end else if (flush_in) begin
      ctrl_q <= CTRL_BUBBLE;
      xfer_q <= '0;
      off_q  <= '0;
    end else if (stall_in) begin
      // Held controls stay put, but an undefined pulse must not repeat.
      ctrl_q.undef <= 1'b0;
    end else begin
      ctrl_q <= ctrl_d;
      xfer_q <= xfer_d;
      off_q  <= off_d;
    end
  end

  assign valid_ex    = ctrl_q.valid;
  assign opcode_ex   = ctrl_q.opcode;
  assign se_ex       = ctrl_q.se;
  assign li_ex       = ctrl_q.li;
  assign rf_ex       = ctrl_q.rf;
  assign rw_ex       = ctrl_q.rw;
  assign b_ex        = ctrl_q.b;
  assign bl_ex       = ctrl_q.bl;
  assign s_ex        = ctrl_q.s;
  assign size_ex     = ctrl_q.size;
  assign undef_ex    = ctrl_q.undef;
  assign xfer_reg_ex = xfer_q;
  assign offset_ex   = off_q;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Self-checking bench for pipelined_control_unit: directed cases followed by
// randomized traffic, compared against a queue-based behavioural model.
module tb_pipelined_control_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] ir_in;
  logic        ir_valid;
  logic [3:0]  flags_in;
  logic        stall_in;
  logic        flush_in;
  logic        hold_fetch_out;
  logic        valid_ex;
  logic [3:0]  opcode_ex;
  logic        se_ex, li_ex, rf_ex, rw_ex, b_ex, bl_ex, s_ex;
  logic [1:0]  size_ex;
  logic [3:0]  xfer_reg_ex;
  logic [5:0]  offset_ex;
  logic        undef_ex;

  int n_checks = 0;
  int n_fail   = 0;

  logic [24:0] m_exp;
  bit          m_busy;
  int          m_q[$];
  int          m_beat;
  bit          m_rw, m_u;

  pipelined_control_unit #(
    .NUM_REGS  (16),
    .REG_IDX_W (4),
    .COND_EN   (1'b1)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .ir_in          (ir_in),
    .ir_valid       (ir_valid),
    .flags_in       (flags_in),
    .stall_in       (stall_in),
    .flush_in       (flush_in),
    .hold_fetch_out (hold_fetch_out),
    .valid_ex       (valid_ex),
    .opcode_ex      (opcode_ex),
    .se_ex          (se_ex),
    .li_ex          (li_ex),
    .rf_ex          (rf_ex),
    .rw_ex          (rw_ex),
    .b_ex           (b_ex),
    .bl_ex          (bl_ex),
    .s_ex           (s_ex),
    .size_ex        (size_ex),
    .xfer_reg_ex    (xfer_reg_ex),
    .offset_ex      (offset_ex),
    .undef_ex       (undef_ex)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [24:0] obs_vec();
    return {valid_ex, opcode_ex, se_ex, li_ex, rf_ex, rw_ex, b_ex, bl_ex, s_ex,
            size_ex, xfer_reg_ex, offset_ex, undef_ex};
  endfunction

  function automatic logic [24:0] mk(input bit valid, input logic [3:0] op, input bit se,
                                     input bit li, input bit rf, input bit rw, input bit b,
                                     input bit bl, input bit s, input logic [1:0] size,
                                     input int xreg, input int off, input bit undef);
    logic [3:0] x;
    logic [5:0] o;
    x = xreg[3:0];
    o = off[5:0];
    return {valid, op, se, li, rf, rw, b, bl, s, size, x, o, undef};
  endfunction

  // ARM pairs conditions: odd codes invert the even code below them; 1111 inverts AL.
  function automatic bit m_cond(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  function automatic logic [24:0] m_beat_vec(input int idx, input int off);
    return mk(1, m_u ? 4'd4 : 4'd2, 0, 1, m_rw, m_rw, 0, 0, 0, 2'd2, idx, off, 0);
  endfunction

  task automatic model_reset();
    m_exp  = '0;
    m_busy = 0;
    m_q.delete();
    m_beat = 0;
  endtask

  task automatic model_step(input logic [31:0] ir, input bit iv, input logic [3:0] fl,
                            input bit st, input bit fs);
    int idx;
    logic [3:0] op;
    if (fs) begin
      m_exp  = '0;
      m_busy = 0;
      m_q.delete();
    end else if (st) begin
      m_exp[0] = 1'b0;
    end else if (m_busy) begin
      idx    = m_q.pop_front();
      m_exp  = m_beat_vec(idx, m_beat * 4);
      m_beat = m_beat + 1;
      m_busy = (m_q.size() != 0);
    end else begin
      m_exp = '0;
      if (iv && m_cond(ir[31:28], fl)) begin
        case (ir[27:25])
          3'd0, 3'd1: begin
            op    = ir[24:21];
            m_exp = mk(1, op, ir[27:25] == 3'd0, 0, !(op >= 4'd8 && op <= 4'd11), 0, 0, 0,
                       ir[20], 2'd0, 0, 0, 0);
          end
          3'd2, 3'd3:
            m_exp = mk(1, ir[23] ? 4'd4 : 4'd2, ir[27:25] == 3'd3, 1, ir[20], ir[20], 0, 0, 0,
                       ir[22] ? 2'd0 : 2'd2, 0, 0, 0);
          3'd5: m_exp = mk(1, 4'd4, 0, 0, ir[24], 0, 1, ir[24], 0, 2'd0, 0, 0, 0);
          3'd4: begin
            m_rw = ir[20];
            m_u  = ir[23];
            for (int i = 0; i < 16; i++) if (ir[i]) m_q.push_back(i);
            if (m_q.size() == 0) begin
              m_exp[0] = 1'b1;
            end else begin
              idx    = m_q.pop_front();
              m_exp  = m_beat_vec(idx, 0);
              m_beat = 1;
              m_busy = (m_q.size() != 0);
            end
          end
          default: m_exp[0] = 1'b1;
        endcase
      end
    end
  endtask

  task automatic step(input logic [31:0] ir, input bit iv, input logic [3:0] fl,
                      input bit st, input bit fs, input string tag);
    ir_in    = ir;
    ir_valid = iv;
    flags_in = fl;
    stall_in = st;
    flush_in = fs;
    model_step(ir, iv, fl, st, fs);
    @(posedge clk);
    #1;
    chk({tag, ".ctl"}, {7'd0, obs_vec()}, {7'd0, m_exp});
    chk({tag, ".hold"}, {31'd0, hold_fetch_out}, {31'd0, m_busy});
  endtask

  localparam logic [31:0] I_ADD   = 32'hE0821003;
  localparam logic [31:0] I_CMP   = 32'hE1520003;
  localparam logic [31:0] I_ADDEQ = 32'h00821003;
  localparam logic [31:0] I_LDM   = 32'hE8900016;
  localparam logic [31:0] I_LDM0  = 32'hE8900000;
  localparam logic [31:0] I_UND   = 32'hEE000000;

  initial begin
    logic [31:0] ir;
    logic [3:0]  fl;
    bit          iv, st, fs;
    int          cls;

    reset_n  = 1'b0;
    ir_in    = '0;
    ir_valid = 1'b0;
    flags_in = '0;
    stall_in = 1'b0;
    flush_in = 1'b0;
    model_reset();
    #12;
    chk("reset.ctl", {7'd0, obs_vec()}, 32'd0);
    chk("reset.hold", {31'd0, hold_fetch_out}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    step(I_ADD,   1, 4'b0000, 0, 0, "add");
    step(I_CMP,   1, 4'b0000, 0, 0, "cmp");
    step(I_ADDEQ, 1, 4'b0000, 0, 0, "addeq_fail");
    step(I_ADDEQ, 1, 4'b0100, 0, 0, "addeq_pass");

    step(I_LDM, 1, 4'b0000, 0, 0, "ldm.b0");
    step(I_LDM, 1, 4'b0000, 0, 0, "ldm.b1");
    step(I_LDM, 1, 4'b0000, 0, 0, "ldm.b2");
    chk("ldm.last_reg", {28'd0, xfer_reg_ex}, 32'd4);
    chk("ldm.last_off", {26'd0, offset_ex}, 32'd8);
    step(I_ADD, 1, 4'b0000, 0, 0, "ldm.after");

    step(I_LDM, 1, 4'b0000, 0, 0, "stall.b0");
    step(I_LDM, 1, 4'b0000, 0, 0, "stall.b1");
    step(I_LDM, 1, 4'b0000, 1, 0, "stall.hold1");
    step(I_LDM, 1, 4'b0000, 1, 0, "stall.hold2");
    step(I_LDM, 1, 4'b0000, 0, 0, "stall.b2");
    step(I_ADD, 1, 4'b0000, 0, 0, "stall.after");

    step(I_LDM, 1, 4'b0000, 0, 0, "flush.b0");
    step(I_LDM, 1, 4'b0000, 1, 1, "flush.squash");
    step(I_ADD, 1, 4'b0000, 0, 0, "flush.after");

    step(I_UND,  1, 4'b0000, 0, 0, "undef.cls7");
    step(I_ADD,  1, 4'b0000, 0, 0, "undef.cls7_end");
    step(I_LDM0, 1, 4'b0000, 0, 0, "undef.empty");
    step(I_LDM0, 1, 4'b0000, 1, 0, "undef.stall_clear");
    step(I_UND,  0, 4'b0000, 0, 0, "undef.not_valid");

    // Asynchronous reset in the middle of a long transfer.
    step(32'hE890FFFE, 1, 4'b0000, 0, 0, "arst.b0");
    step(32'hE890FFFE, 1, 4'b0000, 0, 0, "arst.b1");
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst.ctl", {7'd0, obs_vec()}, 32'd0);
    chk("arst.hold", {31'd0, hold_fetch_out}, 32'd0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;

    ir = I_ADD;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!m_busy) begin
        ir  = $urandom;
        cls = $urandom_range(0, 7);
        ir[27:25] = cls[2:0];
        if ($urandom_range(0, 1) == 0) ir[31:28] = 4'b1110;
        if (cls == 4) begin
          ir[15:0] = 16'($urandom & $urandom);
          if ($urandom_range(0, 7) == 0) ir[15:0] = 16'd0;
        end
      end
      fl = 4'($urandom);
      iv = ($urandom_range(0, 7) != 0);
      st = ($urandom_range(0, 7) == 0);
      fs = ($urandom_range(0, 19) == 0);
      step(ir, iv, fl, st, fs, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
